// File: rtl/booth_issue_ctrl_if.sv
// booth_issue_ctrl_if: upstream operand handshake, multiplier drive and result bundle
// slave  : controller view (accepts operand pairs, drives the multiplier, returns results)
// master : environment view (pushes operand pairs, supplies the multiplier product)
interface booth_issue_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_m;
  logic [4:0] in_q;
  logic       start;
  logic [4:0] M;
  logic [4:0] Q;
  logic [7:0] result;
  logic       out_valid;
  logic [7:0] out_result;
  logic       mismatch;
  modport slave (
    input  in_valid, in_m, in_q, result,
    output in_ready, start, M, Q, out_valid, out_result, mismatch
  );
  modport master (
    output in_valid, in_m, in_q, result,
    input  in_ready, start, M, Q, out_valid, out_result, mismatch
  );
endinterface

// File: rtl/booth_issue_ctrl.sv
// booth_issue_ctrl: operand FIFO feeding a fixed-latency booth multiplier, one pair in flight
// clk   : rising-edge clock
// n_rst : asynchronous active-low reset
// bus   : booth_issue_ctrl_if.slave (in_valid/in_ready/in_m/in_q in, start/M/Q/result to the
//         multiplier, out_valid/out_result/mismatch out)
// BOOTH_ISSUE_CHECK_EN : when defined, compares result with signed(M)*signed(Q) in DONE
module booth_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int MUL_LAT = 6
) (
  input  logic               clk,
  input  logic               n_rst,
  booth_issue_ctrl_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(MUL_LAT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t        state_q;
  logic [4:0]    mem_m [DEPTH];
  logic [4:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic [LW-1:0] lat_q;
  logic [4:0]    m_q, q_q;
  logic [7:0]    res_q;
  logic          start_q, out_valid_q, mismatch_q, mismatch_d;
  logic          full, empty, push, pop;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign push  = bus.in_valid & ~full;
  assign pop   = state_q == ISSUE;
  assign cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
`ifdef BOOTH_ISSUE_CHECK_EN
  logic signed [9:0] prod;
  assign prod       = $signed(m_q) * $signed(q_q);
  assign mismatch_d = prod[7:0] != bus.result;
`else
  assign mismatch_d = 1'b0;
`endif
  always_ff @(posedge clk)
    if (push) begin
      mem_m[wr_q] <= bus.in_m;
      mem_q[wr_q] <= bus.in_q;
    end
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
    end
  // M/Q are loaded on entry to ISSUE so they are valid alongside the start pulse;
  // the counter ends WAIT so that DONE samples result exactly MUL_LAT cycles after start.
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      m_q         <= '0;
      q_q         <= '0;
      res_q       <= '0;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      mismatch_q  <= 1'b0;
      case (state_q)
        IDLE:
          if (!empty) begin
            state_q <= ISSUE;
            start_q <= 1'b1;
            m_q     <= mem_m[rd_q];
            q_q     <= mem_q[rd_q];
          end
        ISSUE: begin
          state_q <= WAIT;
          lat_q   <= LW'(MUL_LAT - 1);
        end
        WAIT: begin
          lat_q <= lat_q - 1'b1;
          if (lat_q == LW'(1)) state_q <= DONE;
        end
        DONE: begin
          state_q     <= IDLE;
          res_q       <= bus.result;
          out_valid_q <= 1'b1;
          mismatch_q  <= mismatch_d;
        end
      endcase
    end
  assign bus.in_ready   = ~full;
  assign bus.start      = start_q;
  assign bus.M          = m_q;
  assign bus.Q          = q_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = res_q;
  assign bus.mismatch   = mismatch_q;
endmodule

// File: tb/tb_booth_issue_ctrl.sv
// tb_booth_issue_ctrl: directed bench for booth_issue_ctrl with a fixed-latency multiplier model
module tb_booth_issue_ctrl;
  localparam int MUL_LAT = 6;
`ifdef BOOTH_ISSUE_CHECK_EN
  localparam int EXP_MM = 1;
`else
  localparam int EXP_MM = 0;
`endif
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic force_zero = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int acc_cyc = 0;
  int lat_c = 0;
  logic [7:0] prod_r = 8'h00;
  int st_q[$];
  int ov_c[$];
  int mm_q[$];
  logic [7:0] ov_r[$];
  logic [7:0] exp_full [6] = '{8'h01, 8'h06, 8'h00, 8'hFA, 8'h14, 8'h19};
  booth_issue_ctrl_if bif();
  booth_issue_ctrl #(.DEPTH(4), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bif.slave)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [7:0] mul8(input logic [4:0] a, input logic [4:0] b);
    logic signed [9:0] p;
    p = $signed(a) * $signed(b);
    return p[7:0];
  endfunction
  // multiplier model: product is valid only in the cycle exactly MUL_LAT after start
  always @(posedge clk)
    if (bif.start) begin
      lat_c  <= 1;
      prod_r <= mul8(bif.M, bif.Q);
    end else if (lat_c != 0 && lat_c < 1000) lat_c <= lat_c + 1;
  assign bif.result = force_zero ? 8'h00 : (lat_c == MUL_LAT ? prod_r : 8'hAA);
  always @(negedge clk)
    if (n_rst) begin
      if (bif.start) st_q.push_back(cyc);
      if (bif.out_valid) begin
        ov_c.push_back(cyc);
        ov_r.push_back(bif.out_result);
      end
      if (bif.mismatch) mm_q.push_back(cyc);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic clear();
    st_q.delete();
    ov_c.delete();
    ov_r.delete();
    mm_q.delete();
  endtask
  task automatic push(input int m, input int q);
    int n = 0;
    while (bif.in_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_ready", bif.in_ready, 1);
    bif.in_valid = 1'b1;
    bif.in_m = m[4:0];
    bif.in_q = q[4:0];
    acc_cyc = cyc;
    @(negedge clk);
    bif.in_valid = 1'b0;
  endtask
  task automatic wait_st(input int n);
    int k = 0;
    while (st_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("start_count", st_q.size(), n);
  endtask
  task automatic wait_ov(input int n);
    int k = 0;
    while (ov_r.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("ov_count", ov_r.size(), n);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    bif.in_valid = 1'b0;
    bif.in_m = '0;
    bif.in_q = '0;
    tick(3);
    check("rst_start", bif.start, 0);
    check("rst_M", bif.M, 0);
    check("rst_Q", bif.Q, 0);
    check("rst_ov", bif.out_valid, 0);
    check("rst_res", bif.out_result, 0);
    check("rst_mm", bif.mismatch, 0);
    check("rst_ready", bif.in_ready, 1);
    n_rst = 1'b1;
    tick(2);
    push(-8, 2);
    wait_ov(1);
    tick(2);
    check("single_starts", st_q.size(), 1);
    check("single_lat", ov_c[0] - st_q[0], MUL_LAT + 1);
    check("single_res", ov_r[0], 8'hF0);
    check("single_mm", mm_q.size(), 0);
    clear();
    tick(20);
    check("idle_starts", st_q.size(), 0);
    check("idle_ov", ov_r.size(), 0);
    clear();
    push(3, 3);
    push(-1, -1);
    push(7, -2);
    wait_ov(3);
    tick(2);
    check("b2b_starts", st_q.size(), 3);
    check("b2b_gap1", st_q[1] - st_q[0], MUL_LAT + 2);
    check("b2b_gap2", st_q[2] - st_q[1], MUL_LAT + 2);
    check("b2b_res0", ov_r[0], 8'h09);
    check("b2b_res1", ov_r[1], 8'h01);
    check("b2b_res2", ov_r[2], 8'hF2);
    check("b2b_mm", mm_q.size(), 0);
    clear();
    push(1, 1);
    wait_st(1);
    tick(1);
    push(2, 3);
    push(-16, -16);
    push(-2, 3);
    push(4, 5);
    check("full_ready", bif.in_ready, 0);
    push(-5, -5);
    check("full_acc_after_pop", acc_cyc, st_q.size() > 1 ? st_q[1] + 1 : -1);
    wait_ov(6);
    tick(2);
    for (int i = 0; i < 6; i++) check($sformatf("full_res%0d", i), ov_r[i], exp_full[i]);
    clear();
    push(3, 3);
    push(1, 1);
    push(2, 2);
    wait_st(1);
    tick(2);
    n_rst = 1'b0;
    #1;
    check("mid_rst_start", bif.start, 0);
    check("mid_rst_M", bif.M, 0);
    check("mid_rst_Q", bif.Q, 0);
    check("mid_rst_ov", bif.out_valid, 0);
    check("mid_rst_res", bif.out_result, 0);
    check("mid_rst_mm", bif.mismatch, 0);
    check("mid_rst_ready", bif.in_ready, 1);
    tick(2);
    n_rst = 1'b1;
    tick(MUL_LAT + 10);
    check("mid_rst_no_ov", ov_r.size(), 0);
    check("mid_rst_no_start", st_q.size(), 1);
    push(-3, 5);
    wait_ov(1);
    tick(2);
    check("post_rst_res", ov_r[0], 8'hF1);
    check("post_rst_starts", st_q.size(), 2);
    clear();
    force_zero = 1'b1;
    push(3, 3);
    wait_ov(1);
    tick(2);
    force_zero = 1'b0;
    check("mm_res", ov_r[0], 8'h00);
    check("mm_cnt", mm_q.size(), EXP_MM);
`ifdef BOOTH_ISSUE_CHECK_EN
    check("mm_cycle", mm_q[0], ov_c[0]);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
